// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package instr_encoder_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned SRC_W = 3;

    // Immediate format selector; encodings 5..7 are illegal.
    typedef enum logic [SRC_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

    // RV32I major opcodes.
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

    // Representable immediate ranges per format.
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -(1 << 20);
    localparam int IMMJ_MAX  = (1 << 20) - 2;

    // Packed word plus error sideband carried through the pipeline.
    typedef struct packed {
        logic [XLEN-1:0] word;
        logic            err;
    } enc_word_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input and instruction output handshake bus of the encoder.
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [SRC_W-1:0]     immSrc;
    logic [OPC_W-1:0]     opcode;
    logic [REG_W-1:0]     rd;
    logic [F3_W-1:0]      funct3;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic [XLEN-1:0]      imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      instr;
    logic                 out_err;

    modport master (
        output in_valid, immSrc, opcode, rd, funct3, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, instr, out_err
    );

    modport slave (
        input  in_valid, immSrc, opcode, rd, funct3, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, instr, out_err
    );

endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: fields + immediate -> RV32I word and error flag.
// Build option ENC_RANGE_CHK_EN adds immediate-representability checking.
module instr_encoder_imm_pack
    import instr_encoder_pkg::*;
(
    input  logic [SRC_W-1:0] imm_src,
    input  logic [OPC_W-1:0] opcode,
    input  logic [REG_W-1:0] rd,
    input  logic [F3_W-1:0]  funct3,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  word_c,
    output logic             err_c
);

    logic illegal_c;

    // Place immediate bits per format; unused fields stay zero.
    always_comb begin
        word_c    = {25'b0, opcode};
        illegal_c = 1'b0;
        case (imm_src)
            IMM_I:   word_c = {imm[11:0], rs1, funct3, rd, opcode};
            IMM_S:   word_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            IMM_B:   word_c = {imm[12], imm[10:5], rs2, rs1, funct3,
                               imm[4:1], imm[11], opcode};
            IMM_J:   word_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            IMM_U:   word_c = {imm[31:12], rd, opcode};
            default: illegal_c = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHK_EN
    logic               range_err_c;
    logic signed [31:0] simm;

    assign simm = $signed(imm);

    // Flag immediates the selected format cannot represent exactly.
    always_comb begin
        range_err_c = 1'b0;
        case (imm_src)
            IMM_I, IMM_S: range_err_c = (simm < IMM12_MIN) || (simm > IMM12_MAX);
            IMM_B:        range_err_c = (simm < IMMB_MIN) || (simm > IMMB_MAX) || imm[0];
            IMM_J:        range_err_c = (simm < IMMJ_MIN) || (simm > IMMJ_MAX) || imm[0];
            IMM_U:        range_err_c = |imm[11:0];
            default:      range_err_c = 1'b0;
        endcase
    end

    assign err_c = illegal_c | range_err_c;
`else
    assign err_c = illegal_c;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: 2-stage valid/ready pipeline around
// the immediate packer, with an emitted-instruction counter.
// Build option ENC_RANGE_CHK_EN enables immediate range errors.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst,
    instr_encoder_if.slave   bus,
    output logic [CNT_W-1:0] enc_count
);

    logic [XLEN-1:0] pack_word_c;
    logic            pack_err_c;
    enc_word_t       s1_q;
    enc_word_t       s2_q;
    logic            s1_valid;
    logic            s2_valid;
    logic            s2_free_c;
    logic            s1_free_c;
    logic            emit_c;

    instr_encoder_imm_pack u_pack (
        .imm_src (bus.immSrc),
        .opcode  (bus.opcode),
        .rd      (bus.rd),
        .funct3  (bus.funct3),
        .rs1     (bus.rs1),
        .rs2     (bus.rs2),
        .imm     (bus.imm),
        .word_c  (pack_word_c),
        .err_c   (pack_err_c)
    );

    // A stage may load when empty or when its content moves on this cycle.
    assign s2_free_c    = !s2_valid || bus.out_ready;
    assign s1_free_c    = !s1_valid || s2_free_c;
    assign emit_c       = s2_valid && bus.out_ready;
    assign bus.in_ready = s1_free_c;

    // Pipeline stages and emitted-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            s2_valid  <= 1'b0;
            s2_q      <= '0;
            enc_count <= '0;
        end else begin
            if (s1_free_c) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_q.word <= pack_word_c;
                    s1_q.err  <= pack_err_c;
                end
            end
            if (s2_free_c) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_q <= s1_q;
                end
            end
            if (emit_c) begin
                enc_count <= enc_count + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.instr     = s2_q.word;
    assign bus.out_err   = s2_q.err;

endmodule
